// File: rtl/riscv23_pkg.sv
// Shared IITB-RISC-23 definitions: datapath width, fetch constants and the
// opcode encodings used by decode.
package riscv23_pkg;

  localparam int          XLEN         = 16;
  localparam logic [15:0] PC_STEP      = 16'd2;
  localparam logic [15:0] RESET_PC     = 16'h0000;
  localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

  typedef enum logic [3:0] {
    OP_ADI  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_NAND = 4'b0010,
    OP_LLI  = 4'b0011,
    OP_LW   = 4'b0100,
    OP_SW   = 4'b0101,
    OP_LM   = 4'b0110,
    OP_SM   = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_JAL  = 4'b1100,
    OP_JLR  = 4'b1101
  } opcode_e;

  // Address arithmetic wraps modulo 2^16.
  function automatic logic [XLEN-1:0] pc_add(input logic [XLEN-1:0] pc,
                                             input logic [XLEN-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/PC skid buffer. Captures the fetch return that lands
// while decode is stalled, so it can be replayed once the stall releases.
module fetch_hold_buf
  import riscv23_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IITB-RISC-23 instruction fetch: owns the PC, issues to a 1-cycle synchronous
// instruction memory and fills the IF/ID register with stall and redirect.
module fetch_stage
  import riscv23_pkg::*;
#(
  parameter logic [15:0] RESET_PC = riscv23_pkg::RESET_PC,
  parameter logic [15:0] PC_STEP  = riscv23_pkg::PC_STEP
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic [XLEN-1:0] imem_addr_o,
  output logic            imem_rd_o,
  input  logic [XLEN-1:0] imem_data_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc_plus2_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            infl_q;
  logic [XLEN-1:0] infl_pc_q;

  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0] if_id_pc_plus2_q, if_id_pc_plus2_d;

  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            hold_load;
  logic            hold_drain;

  // A redirect issues its target even under stall; sequential issue waits.
  always_comb begin
    imem_addr_o = redirect_valid_i ? redirect_pc_i : pc_q;
    imem_rd_o   = 1'b0;
    if (!reset_i) imem_rd_o = redirect_valid_i | ~stall_i;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i)  pc_d = pc_add(redirect_pc_i, PC_STEP);
    else if (imem_rd_o)    pc_d = pc_add(pc_q, PC_STEP);
  end

  assign hold_load  = ~redirect_valid_i & stall_i & infl_q;
  assign hold_drain = ~redirect_valid_i & ~stall_i & hold_valid;

  fetch_hold_buf u_hold (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (redirect_valid_i),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .instr_i (imem_data_i),
    .pc_i    (infl_pc_q),
    .valid_o (hold_valid),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  // Nothing issues during a stall, so a draining hold never races a return.
  always_comb begin
    if_id_valid_d    = if_id_valid_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus2_d = if_id_pc_plus2_q;
    if (redirect_valid_i) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = BUBBLE_INSTR;
    end else if (!stall_i) begin
      if (hold_valid) begin
        if_id_valid_d    = 1'b1;
        if_id_instr_d    = hold_instr;
        if_id_pc_d       = hold_pc;
        if_id_pc_plus2_d = pc_add(hold_pc, PC_STEP);
      end else if (infl_q) begin
        if_id_valid_d    = 1'b1;
        if_id_instr_d    = imem_data_i;
        if_id_pc_d       = infl_pc_q;
        if_id_pc_plus2_d = pc_add(infl_pc_q, PC_STEP);
      end else begin
        if_id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q             <= RESET_PC;
      infl_q           <= 1'b0;
      infl_pc_q        <= '0;
      if_id_valid_q    <= 1'b0;
      if_id_instr_q    <= '0;
      if_id_pc_q       <= '0;
      if_id_pc_plus2_q <= '0;
    end else begin
      pc_q             <= pc_d;
      infl_q           <= imem_rd_o;
      infl_pc_q        <= imem_addr_o;
      if_id_valid_q    <= if_id_valid_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus2_q <= if_id_pc_plus2_d;
    end
  end

  assign if_id_valid_o    = if_id_valid_q;
  assign if_id_instr_o    = if_id_instr_q;
  assign if_id_pc_o       = if_id_pc_q;
  assign if_id_pc_plus2_o = if_id_pc_plus2_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the IITB-RISC-23 pipeline. Sits directly upstream of decode.
- Owns the PC and drives the synchronous instruction memory, which returns data 1 cycle after the address.
- Produces the IF/ID pipeline register consumed by decode.
- Honours stall from decode/hazard logic and redirect (branch/jump) from later stages. A redirect always squashes wrong-path fetches.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential 16-bit instruction.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  16  instruction memory address, combinational.
- imem_rd  out  1  instruction memory read enable, combinational.
- imem_data  in  16  instruction word, valid the cycle after imem_rd=1.
- stall_in  in  1  decode cannot accept; hold IF/ID.
- redirect_valid  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  16  redirect target.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  16  fetched instruction.
- if_id_pc  out  16  address of if_id_instr.
- if_id_pc_plus2  out  16  if_id_pc + PC_STEP, mod 2^16.

Behaviour:
Internal state:
- pc_q: next sequential fetch address.
- infl_q, infl_pc_q: one request outstanding, and its address.
- hold_valid_q, hold_instr_q, hold_pc_q: one-entry hold buffer.
- IF/ID register.

Reset (reset=1 at a posedge):
- pc_q=RESET_PC; infl_q=0; hold_valid_q=0.
- if_id_valid=0; if_id_instr=0; if_id_pc=0; if_id_pc_plus2=0.
- imem_rd=0 while reset is high.
- Reset mid-operation discards in-flight data and the hold buffer. Fetch restarts at RESET_PC.

Combinational issue logic:
- If redirect_valid: imem_addr=redirect_pc, imem_rd=1, regardless of stall_in.
- Else: imem_addr=pc_q, imem_rd=!stall_in.

pc_q update:
- On redirect: pc_q <= redirect_pc+PC_STEP.
- On a sequential issue: pc_q <= pc_q+PC_STEP.
- 16-bit wrap: 16'hFFFE -> 16'h0000.

In-flight tracking:
- infl_q <= imem_rd; infl_pc_q <= imem_addr.
- At most one request is in flight at any time.

IF/ID update, in priority order (reset first, then the cases below):
1. redirect_valid:
   - if_id_valid<=0 (bubble); hold_valid_q<=0.
   - Returning imem_data is discarded, which squashes the wrong path.
2. stall_in (no redirect):
   - IF/ID holds all fields.
   - If infl_q: hold_instr_q<=imem_data, hold_pc_q<=infl_pc_q, hold_valid_q<=1.
   - Hold cannot overflow, because no new issue occurs while stalled.
3. Not stalled:
   - If hold_valid_q: load IF/ID from hold, hold_valid_q<=0. Any in-flight return this cycle cannot exist, since nothing was issued during the stall.
   - Else if infl_q: load IF/ID from imem_data / infl_pc_q.
   - Else: if_id_valid<=0.

Other rules:
- if_id_pc_plus2 is registered together with if_id_pc.
- Latencies:
  - Sequential: first instruction is valid in IF/ID 2 cycles after reset deasserts.
  - Steady state: 1 instruction per cycle.
  - Redirect asserted at cycle N: target instruction valid in IF/ID at the end of cycle N+1, with exactly one bubble.
- Stall released: buffered instruction appears the next cycle, with no loss and no duplication.
- Redirect and stall together: redirect wins and IF/ID becomes a bubble. Decode must treat a bubble as harmless while stalled.
- Instruction content is not interpreted.

Decomposition:
- Package riscv23_pkg holds:
  - XLEN=16, PC_STEP, RESET_PC.
  - The 4-bit opcode constants used by decode: ADD=0001, ADI=0000, NAND=0010, LLI=0011, LW=0100, SW=0101, LM=0110, SM=0111, BEQ=1000, JAL=1100, JLR=1101.
  - BUBBLE_INSTR=16'h0000.
- One sub-module, fetch_hold_buf: a one-entry instr+pc skid buffer with load/drain/clear controls.
- PC and IF/ID logic remain in fetch_stage.

Test Plan:
The bench memory model returns imem_data = ~addr one cycle after imem_rd=1.
- Reset, then free-run 5 cycles:
  - imem_addr sequence is 0,2,4,6,...
  - From cycle 2 onward, IF/ID shows (pc=0, instr=FFFF), (2, FFFD), (4, FFFB), with valid=1 each cycle.
  - if_id_pc_plus2 = pc+2.
- Stall for 3 cycles while IF/ID holds pc=4:
  - IF/ID stays at pc=4; imem_rd=0 during the stall.
  - On release, IF/ID shows pc=6 then pc=8.
  - No instruction is skipped or duplicated.
- Redirect to 16'h0100 while IF/ID=pc 6:
  - Next cycle: if_id_valid=0.
  - Following cycle: IF/ID pc=0100, instr=FEFF; then pc=0102.
  - The pc=8 fetch never appears in IF/ID.
- Redirect to 16'h0040 asserted during an active stall with the hold buffer full:
  - Hold is cleared and imem_addr=0040.
  - IF/ID shows a bubble, then pc=0040 once stall drops.
- Redirect to 16'hFFFC, then free-run:
  - pcs are FFFC, FFFE, 0000, 0002 (wrap).
  - if_id_pc_plus2 for FFFE is 0000.
- Assert reset for 1 cycle mid-stream (e.g. while stalled with hold full):
  - All outputs read 0 and valid=0.
  - The fetch sequence restarts at pc=0, and the stale hold entry is never emitted.
